// File: rtl/mem_moc_responder.sv
// rtl/mem_moc_responder.sv - byte-addressed big-endian RAM answering the MFA/MOC memory handshake
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset    asynchronous active-low reset
//   MFA      memory function active, request valid while high
//   RW       1 = read, 0 = write
//   Size     00 byte, 01 halfword, 10 word, 11 reserved
//   Address  byte address (ADDR_WIDTH bits)
//   DataIn   right-justified write data
//   DataOut  right-justified, zero-extended read data
//   MOC      memory operation complete
module mem_moc_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MFA,
    input  logic                  RW,
    input  logic [1:0]            Size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic [1:0]              size_q;
    logic [31:0]             din_q;
    logic [31:0]             dout_q;
    logic                    moc_q;

    // Not reset: contents survive reset and are preloaded externally.
    logic [7:0]              mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
    logic [31:0]             rdata;
    logic                    access;
    logic                    mem_we;

    // Aligned base address; successive byte indices wrap within the array.
    always_comb begin
        a0 = addr_q;
        case (size_q)
            2'b01:   a0 = {addr_q[ADDR_WIDTH-1:1], 1'b0};
            2'b10:   a0 = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            default: a0 = addr_q;
        endcase
        a1 = a0 + ADDR_WIDTH'(1);
        a2 = a0 + ADDR_WIDTH'(2);
        a3 = a0 + ADDR_WIDTH'(3);
    end

    always_comb begin
        rdata = 32'h0;
        case (size_q)
            2'b00:   rdata = {24'h0, mem[a0]};
            2'b01:   rdata = {16'h0, mem[a0], mem[a1]};
            2'b10:   rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: rdata = 32'h0;
        endcase
    end

    // The access happens on the edge that ends the wait phase; an abort
    // (MFA low) or reset in WAIT therefore never reaches the array.
    assign access = (state_q == WAIT) && MFA && (cnt_q == 4'd0);
    assign mem_we = access && !rw_q && (size_q != 2'b11);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (size_q)
                2'b00: mem[a0] <= din_q[7:0];
                2'b01: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                2'b10: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    moc_q <= 1'b0;
                    if (MFA) begin
                        addr_q  <= Address;
                        rw_q    <= RW;
                        size_q  <= Size;
                        din_q   <= DataIn;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!MFA) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        moc_q   <= 1'b1;
                        state_q <= ACK;
                        if (size_q == 2'b11) begin
                            dout_q <= 32'h0;
                        end else if (rw_q) begin
                            dout_q <= rdata;
                        end
                    end
                end
                ACK: begin
                    // Holding MFA keeps us here; only its release frees the bus.
                    if (!MFA) begin
                        moc_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    moc_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;

endmodule
